wb_result_select_pipe: RTL and testbench
========================================

// Module: wb_result_select_pipe
// PURPOSE
//  - Parametrised, registered writeback result selector for the MIPS pipeline.
//    Picks one of NUM_SRC candidate results (ALU, memory, link/PC+8, ...) using an
//    encoded select.
//  - Carries the destination register and write enable alongside the result.
//  - Presents the selection through a valid/ready skid stage so the register
//    file port can backpressure.
//  - Sits between the MEM/WB pipeline register and the register-file write port.
// PARAMETERS
//  DATA_W      32  width of each candidate result and of out_data
//  NUM_SRC     3   number of candidate sources (>=2)
//  SEL_W       $clog2(NUM_SRC)  select width (derived; do not override)
//  DEFAULT_SRC 0   source index used when in_sel >= NUM_SRC
//  REG_ADDR_W  5   destination register index width
// PORTS
//  clk       in   1                  single clock, rising edge
//  rst_n     in   1                  asynchronous, active-low reset
//  flush     in   1                  synchronous kill of all buffered entries
//  in_valid  in   1                  upstream entry valid
//  in_ready  out  1                  stage can accept an entry this cycle
//  in_data   in   NUM_SRC*DATA_W     packed candidates; source k at [k*DATA_W +: DATA_W]
//  in_sel    in   SEL_W              encoded source select
//  in_rd     in   REG_ADDR_W         destination register index
//  in_we     in   1                  register write request
//  out_valid out  1                  selected result valid
//  out_ready in   1                  register-file port accepts this cycle
//  out_data  out  DATA_W             selected result
//  out_rd    out  REG_ADDR_W         destination register index
//  out_we    out  1                  write enable; forced 0 when out_rd == 0
//  sel_err   out  1                  (WB_SEL_CHECK_EN only) sticky out-of-range select flag
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
//  - Reset values: out_valid=0, out_data=0, out_rd=0, out_we=0, in_ready=1, sel_err=0.
//    Both entries are empty after reset.
//  - Selection happens on input, before registering:
//    sel_data = in_data[src*DATA_W +: DATA_W], where src = (in_sel < NUM_SRC) ? in_sel : DEFAULT_SRC.
//  - Buffer states:
//    EMPTY : out_valid=0.
//    ONE   : main entry valid, skid entry empty.
//    FULL  : main and skid entries both valid.
//  - in_ready = (state != FULL). It is a registered output with no combinational
//    path from out_ready.
//  - An accept (in_valid & in_ready) and a drain (out_valid & out_ready) may occur
//    in the same cycle.
//  - Transitions (A=accept, D=drain):
//    EMPTY -A-> ONE
//    ONE   -A&!D-> FULL;   ONE -A&D-> ONE (main reloaded);   ONE -!A&D-> EMPTY
//    FULL  -D-> ONE (skid moves to main); no accept is possible while FULL
//  - Latency: one cycle from accept to out_valid when EMPTY or draining. Throughput
//    is one entry per cycle under continuous out_ready.
//  - Ordering: strict FIFO; the skid entry is never presented ahead of main.
//  - out_we = captured in_we & (captured in_rd != 0). This is evaluated at capture
//    and stored.
//  - flush: next state is EMPTY and out_valid=0 the following cycle.
//    flush wins over a simultaneous accept, which is discarded. Data registers
//    keep their values.
//  - Reset mid-operation clears every buffered entry immediately (asynchronous).
//  - A held entry (out_valid & !out_ready) keeps out_data, out_rd and out_we stable
//    until it drains.
// CONFIGURATION
//  - Macro WB_SEL_CHECK_EN.
//  - Defined: sel_err is set on any accept with in_sel >= NUM_SRC. It stays set
//    until reset or flush. The DEFAULT_SRC substitution still applies.
//  - Undefined: the sel_err port and its logic are absent, and out-of-range selects
//    silently use DEFAULT_SRC.
// STRUCTURE
//  - Shared package wb_pkg:
//    typedef wb_entry_t {data, rd, we};
//    constants WB_DEFAULT_DATA_W=32, WB_REG_ADDR_W=5;
//    localparam encoding of the buffer state (EMPTY/ONE/FULL).
//  - One sub-module: wb_nway_select (combinational N-way packed mux with
//    out-of-range default); it outputs sel_data and an out_of_range flag.
//  - The top level holds the skid control FSM and the main and skid entry registers.
// TESTING
//  - Reset: hold rst_n=0, then release. Expect out_valid=0, in_ready=1,
//    out_data=0, and sel_err=0 (when WB_SEL_CHECK_EN is defined).
//  - Select: NUM_SRC=3, in_data={32'hC,32'hB,32'hA}, in_sel=1, out_ready=1.
//    Next cycle out_data=32'hB. With in_sel=3, out_data=32'hA (DEFAULT_SRC=0)
//    and sel_err=1.
//  - Backpressure: hold out_ready=0 and send entries E1 and E2.
//    Expect in_ready=0 after E2 and out_data to stay at E1.
//    Raise out_ready: E1 then E2 come out on consecutive cycles, and in_ready
//    returns to 1.
//  - Simultaneous accept and drain in ONE over 8 back-to-back entries with
//    out_ready=1: the outputs match the inputs in order, one per cycle, and
//    in_ready never drops.
//  - $zero guard: in_rd=0, in_we=1 -> out_we=0. in_rd=5, in_we=1 -> out_we=1, out_rd=5.
//  - Flush in FULL concurrent with in_valid: the next cycle is EMPTY, out_valid=0,
//    and the flushed-cycle entry never appears. Also assert rst_n low mid-stream
//    and expect out_valid=0 immediately.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared writeback definitions: default widths, entry record and skid-buffer state encoding.
package wb_pkg;

   localparam int WB_DEFAULT_DATA_W = 32;
   localparam int WB_REG_ADDR_W     = 5;

   localparam logic [1:0] WB_ST_EMPTY = 2'd0;
   localparam logic [1:0] WB_ST_ONE   = 2'd1;
   localparam logic [1:0] WB_ST_FULL  = 2'd2;

   typedef enum logic [1:0] {
      ST_EMPTY = WB_ST_EMPTY,
      ST_ONE   = WB_ST_ONE,
      ST_FULL  = WB_ST_FULL
   } bufState_t;

   typedef struct packed {
      logic [WB_DEFAULT_DATA_W-1:0] data;
      logic [WB_REG_ADDR_W-1:0]     rd;
      logic                         we;
   } wb_entry_t;

endpackage

// File: rtl/wb_result_select_pipe_if.sv
// Upstream (MEM/WB) and downstream (register-file port) handshake bundle for the writeback selector.
interface wb_result_select_pipe_if
   import wb_pkg::*;
#(
   parameter int DATA_W     = WB_DEFAULT_DATA_W,
   parameter int NUM_SRC    = 3,
   parameter int REG_ADDR_W = WB_REG_ADDR_W
);
   localparam int SEL_W = $clog2(NUM_SRC);

   logic                      in_valid;
   logic                      in_ready;
   logic [NUM_SRC*DATA_W-1:0] in_data;
   logic [SEL_W-1:0]          in_sel;
   logic [REG_ADDR_W-1:0]     in_rd;
   logic                      in_we;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         out_data;
   logic [REG_ADDR_W-1:0]     out_rd;
   logic                      out_we;

   modport master (
      output in_valid, in_data, in_sel, in_rd, in_we, out_ready,
      input  in_ready, out_valid, out_data, out_rd, out_we
   );

   modport slave (
      input  in_valid, in_data, in_sel, in_rd, in_we, out_ready,
      output in_ready, out_valid, out_data, out_rd, out_we
   );

endinterface

// File: rtl/wb_nway_select.sv
// Combinational N-way packed mux; out-of-range selects fall back to DEFAULT_SRC and raise outOfRange.
module wb_nway_select #(
   parameter int DATA_W      = 32,
   parameter int NUM_SRC     = 3,
   parameter int SEL_W       = $clog2(NUM_SRC),
   parameter int DEFAULT_SRC = 0
) (
   input  logic [NUM_SRC*DATA_W-1:0] candData,
   input  logic [SEL_W-1:0]          sel,
   output logic [DATA_W-1:0]         selData,
   output logic                      outOfRange
);

   always_comb begin
      selData    = candData[DEFAULT_SRC*DATA_W +: DATA_W];
      outOfRange = 1'b1;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (sel == SEL_W'(k)) begin
            selData    = candData[k*DATA_W +: DATA_W];
            outOfRange = 1'b0;
         end
      end
   end

endmodule

// File: rtl/wb_result_select_pipe.sv
// Registered writeback result selector with a two-entry valid/ready skid stage.
// Optional WB_SEL_CHECK_EN adds the sticky sel_err out-of-range select flag.
module wb_result_select_pipe
   import wb_pkg::*;
#(
   parameter int DATA_W      = WB_DEFAULT_DATA_W,
   parameter int NUM_SRC     = 3,
   parameter int SEL_W       = $clog2(NUM_SRC),
   parameter int DEFAULT_SRC = 0,
   parameter int REG_ADDR_W  = WB_REG_ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   wb_result_select_pipe_if.slave   bus
`ifdef WB_SEL_CHECK_EN
   ,
   output logic                     sel_err
`endif
);

   typedef struct packed {
      logic [DATA_W-1:0]     data;
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
   } entry_t;

   bufState_t         state, nextState;
   entry_t            mainEntry, skidEntry, newEntry;
   logic              inReadyQ, outValidQ;
   logic              accept, drain;
   logic              loadMain, loadSkid, skidToMain;
   logic [DATA_W-1:0] selData;
   logic              outOfRange;

   wb_nway_select #(
      .DATA_W      (DATA_W),
      .NUM_SRC     (NUM_SRC),
      .SEL_W       (SEL_W),
      .DEFAULT_SRC (DEFAULT_SRC)
   ) u_select (
      .candData   (bus.in_data),
      .sel        (bus.in_sel),
      .selData    (selData),
      .outOfRange (outOfRange)
   );

   // The $zero guard is resolved at capture so the held entry never changes while stalled.
   assign newEntry.data = selData;
   assign newEntry.rd   = bus.in_rd;
   assign newEntry.we   = bus.in_we & (bus.in_rd != '0);

   assign accept = bus.in_valid & inReadyQ;
   assign drain  = outValidQ & bus.out_ready;

   always_comb begin
      nextState  = state;
      loadMain   = 1'b0;
      loadSkid   = 1'b0;
      skidToMain = 1'b0;
      unique case (state)
         ST_EMPTY: begin
            if (accept) begin
               nextState = ST_ONE;
               loadMain  = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && !drain) begin
               nextState = ST_FULL;
               loadSkid  = 1'b1;
            end else if (accept && drain) begin
               loadMain = 1'b1;
            end else if (drain) begin
               nextState = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (drain) begin
               nextState  = ST_ONE;
               skidToMain = 1'b1;
            end
         end
         default: nextState = ST_EMPTY;
      endcase
      // Flush discards any same-cycle accept; entry registers are left untouched.
      if (flush) begin
         nextState  = ST_EMPTY;
         loadMain   = 1'b0;
         loadSkid   = 1'b0;
         skidToMain = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_EMPTY;
         inReadyQ  <= 1'b1;
         outValidQ <= 1'b0;
         mainEntry <= '0;
         skidEntry <= '0;
      end else begin
         state     <= nextState;
         inReadyQ  <= (nextState != ST_FULL);
         outValidQ <= (nextState != ST_EMPTY);
         if (loadMain) begin
            mainEntry <= newEntry;
         end else if (skidToMain) begin
            mainEntry <= skidEntry;
         end
         if (loadSkid) begin
            skidEntry <= newEntry;
         end
      end
   end

`ifdef WB_SEL_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err <= 1'b0;
      end else if (flush) begin
         sel_err <= 1'b0;
      end else if (accept && outOfRange) begin
         sel_err <= 1'b1;
      end
   end
`else
   logic unusedOutOfRange;
   assign unusedOutOfRange = outOfRange;
`endif

   assign bus.in_ready  = inReadyQ;
   assign bus.out_valid = outValidQ;
   assign bus.out_data  = mainEntry.data;
   assign bus.out_rd    = mainEntry.rd;
   assign bus.out_we    = mainEntry.we;

endmodule

// File: tb/tb_wb_result_select_pipe.sv
// Bench for wb_result_select_pipe: directed scenarios plus random traffic against a depth-2 FIFO model.
module tb_wb_result_select_pipe;
   import wb_pkg::*;

   localparam int DW = 32;
   localparam int NS = 3;
   localparam int RW = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
`ifdef WB_SEL_CHECK_EN
   logic selErr;
`endif

   int checks   = 0;
   int failures = 0;

   wb_entry_t q[$];
   bit        errModel = 1'b0;

   wb_result_select_pipe_if #(.DATA_W(DW), .NUM_SRC(NS), .REG_ADDR_W(RW)) bus ();

   wb_result_select_pipe #(
      .DATA_W      (DW),
      .NUM_SRC     (NS),
      .DEFAULT_SRC (0),
      .REG_ADDR_W  (RW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
`ifdef WB_SEL_CHECK_EN
      ,
      .sel_err (selErr)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic setIn(input logic v, input logic [NS*DW-1:0] d, input logic [1:0] s,
                        input logic [RW-1:0] rd, input logic we);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_sel   = s;
      bus.in_rd    = rd;
      bus.in_we    = we;
   endtask

   // Expected entry straight from the selection rule and the $zero guard.
   function automatic wb_entry_t expEntry();
      wb_entry_t e;
      int        src;
      src    = (int'(bus.in_sel) < NS) ? int'(bus.in_sel) : 0;
      e.data = bus.in_data[src*DW +: DW];
      e.rd   = bus.in_rd;
      e.we   = bus.in_we && (bus.in_rd != 0);
      return e;
   endfunction

   task automatic checkOutputs();
      checkVal("out_valid", bus.out_valid, q.size() > 0);
      checkVal("in_ready", bus.in_ready, q.size() < 2);
      if (q.size() > 0) begin
         checkVal("out_data", bus.out_data, q[0].data);
         checkVal("out_rd", bus.out_rd, q[0].rd);
         checkVal("out_we", bus.out_we, q[0].we);
      end
`ifdef WB_SEL_CHECK_EN
      checkVal("sel_err", selErr, errModel);
`endif
   endtask

   // Advance one clock: update the model with the inputs as they stand, then check.
   task automatic step();
      bit        acc, drn;
      wb_entry_t e;
      acc = bus.in_valid && (q.size() < 2);
      drn = (q.size() > 0) && bus.out_ready;
      e   = expEntry();
      if (flush) begin
         q.delete();
         errModel = 1'b0;
      end else begin
         if (drn) void'(q.pop_front());
         if (acc) begin
            q.push_back(e);
            if (int'(bus.in_sel) >= NS) errModel = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      checkOutputs();
   endtask

   initial begin
      setIn(1'b0, '0, 2'd0, '0, 1'b0);
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkVal("rst_out_valid", bus.out_valid, 0);
      checkVal("rst_in_ready", bus.in_ready, 1);
      checkVal("rst_out_data", bus.out_data, 0);
      checkVal("rst_out_we", bus.out_we, 0);
`ifdef WB_SEL_CHECK_EN
      checkVal("rst_sel_err", selErr, 0);
`endif
      rst_n = 1'b1;

      // Select and out-of-range default
      setIn(1'b1, {32'hC, 32'hB, 32'hA}, 2'd1, 5'd3, 1'b1);
      bus.out_ready = 1'b1;
      step();
      checkVal("sel_b", bus.out_data, 32'hB);
      setIn(1'b1, {32'hC, 32'hB, 32'hA}, 2'd3, 5'd3, 1'b1);
      step();
      checkVal("sel_default", bus.out_data, 32'hA);
`ifdef WB_SEL_CHECK_EN
      checkVal("sel_err_set", selErr, 1);
`endif
      setIn(1'b0, '0, 2'd0, '0, 1'b0);
      step();

      // Backpressure
      bus.out_ready = 1'b0;
      setIn(1'b1, {64'h0, 32'hE1}, 2'd0, 5'd1, 1'b1);
      step();
      setIn(1'b1, {64'h0, 32'hE2}, 2'd0, 5'd2, 1'b1);
      step();
      checkVal("bp_full_ready", bus.in_ready, 0);
      checkVal("bp_hold_e1", bus.out_data, 32'hE1);
      setIn(1'b0, '0, 2'd0, '0, 1'b0);
      step();
      checkVal("bp_still_e1", bus.out_data, 32'hE1);
      bus.out_ready = 1'b1;
      step();
      checkVal("bp_e2", bus.out_data, 32'hE2);
      checkVal("bp_ready_back", bus.in_ready, 1);
      step();

      // Back-to-back accept and drain
      for (int i = 0; i < 8; i++) begin
         setIn(1'b1, {$urandom, $urandom, 32'h100 + i}, 2'd0, RW'(i + 1), 1'b1);
         step();
         checkVal("b2b_data", bus.out_data, 32'h100 + i);
         checkVal("b2b_ready", bus.in_ready, 1);
      end

      // $zero guard
      setIn(1'b1, {64'h0, 32'h55}, 2'd0, 5'd0, 1'b1);
      step();
      checkVal("zero_we", bus.out_we, 0);
      setIn(1'b1, {64'h0, 32'h66}, 2'd0, 5'd5, 1'b1);
      step();
      checkVal("rd5_we", bus.out_we, 1);
      checkVal("rd5_rd", bus.out_rd, 5);
      setIn(1'b0, '0, 2'd0, '0, 1'b0);
      step();

      // Flush while FULL with a concurrent valid entry
      bus.out_ready = 1'b0;
      setIn(1'b1, {64'h0, 32'hF1}, 2'd0, 5'd7, 1'b1);
      step();
      setIn(1'b1, {64'h0, 32'hF2}, 2'd0, 5'd8, 1'b1);
      step();
      checkVal("fl_full", bus.in_ready, 0);
      setIn(1'b1, {64'h0, 32'hDEAD}, 2'd0, 5'd9, 1'b1);
      flush = 1'b1;
      step();
      checkVal("fl_empty", bus.out_valid, 0);
      flush = 1'b0;
      setIn(1'b0, '0, 2'd0, '0, 1'b0);
      bus.out_ready = 1'b1;
      step();
      step();
      checkVal("fl_no_ghost", bus.out_valid, 0);

      // Random traffic with an asynchronous reset in the middle
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            bus.out_ready = 1'b0;
            setIn(1'b1, {$urandom, $urandom, $urandom}, 2'd2, 5'd4, 1'b1);
            flush = 1'b0;
            step();
            #2;
            rst_n = 1'b0;
            #1;
            checkVal("async_rst_valid", bus.out_valid, 0);
            checkVal("async_rst_ready", bus.in_ready, 1);
            q.delete();
            errModel = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         setIn($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom},
               2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? RW'(0) : RW'($urandom_range(1, 31)),
               1'($urandom_range(0, 1)));
         bus.out_ready = ((i / 25) % 3 == 1) ? ($urandom_range(0, 4) == 0)
                                              : ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 19) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
